karatsuba8_arbiter: RTL

KARATSUBA8_ARBITER -- requirements
Module: karatsuba8_arbiter

---
 rtl/karatsuba8_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/karatsuba8_arbiter.sv
// karatsuba8_arbiter
// Shares one external karatsuba8 multiplier between two requesters using a
// round-robin grant. A granted requester's operands are latched and presented
// on m_x/m_y with m_start held high until the multiplier reports m_done; the
// result is then latched into that requester's product register and a
// one-cycle ack is pulsed. The arbiter waits for m_done to fall before it
// accepts the next request.
//
// Ports
//   clk              single clock, rising edge
//   rst              synchronous active-low reset
//   req0/req1        request, held high with stable operands until ack
//   a0/b0, a1/b1     8-bit operands per requester
//   ack0/ack1        one-cycle completion pulse per requester
//   p0/p1            16-bit product per requester, held until the next ack
//   m_start          multiply request to the shared multiplier
//   m_done           multiplier completion, may stay high after m_start falls
//   m_x/m_y          operands to the multiplier
//   m_r              multiplier result
//   busy             high whenever the FSM is not idle
//   owner            channel currently or most recently granted
//   err              timeout flag, high for the ACK cycle of an aborted job
//
// Optional feature: define KARATSUBA8_ARB_TIMEOUT_EN to abort a job after 32
// BUSY cycles without m_done. The aborted job is acked with a zero product.
//
// state | meaning
// IDLE  | waiting for a request
// BUSY  | m_start high, waiting for m_done (or timeout)
// ACK   | ack[owner] pulsed, product valid
// DRAIN | waiting for m_done to fall before the next grant

module karatsuba8_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  a0,
    input  logic [7:0]  b0,
    input  logic [7:0]  a1,
    input  logic [7:0]  b1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] p0,
    output logic [15:0] p1,
    output logic        m_start,
    input  logic        m_done,
    output logic [7:0]  m_x,
    output logic [7:0]  m_y,
    input  logic [15:0] m_r,
    output logic        busy,
    output logic        owner,
    output logic        err
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK, S_DRAIN} state_t;

    state_t      state_q, state_d;
    logic        prio_q, prio_d;      // channel with priority on a tie
    logic        owner_q, owner_d;
    logic        m_start_q, m_start_d;
    logic [7:0]  m_x_q, m_x_d;
    logic [7:0]  m_y_q, m_y_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic [15:0] p0_q, p0_d;
    logic [15:0] p1_q, p1_d;
    logic        busy_q, busy_d;
    logic        grant;
`ifdef KARATSUBA8_ARB_TIMEOUT_EN
    logic [4:0]  tmo_q, tmo_d;
    logic        err_q, err_d;
`endif

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        owner_d   = owner_q;
        m_start_d = m_start_q;
        m_x_d     = m_x_q;
        m_y_d     = m_y_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        p0_d      = p0_q;
        p1_d      = p1_q;
        grant     = (req0 && req1) ? prio_q : req1;
`ifdef KARATSUBA8_ARB_TIMEOUT_EN
        tmo_d     = tmo_q;
        err_d     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    owner_d   = grant;
                    prio_d    = ~grant;
                    m_x_d     = grant ? a1 : a0;
                    m_y_d     = grant ? b1 : b0;
                    m_start_d = 1'b1;
                    state_d   = S_BUSY;
`ifdef KARATSUBA8_ARB_TIMEOUT_EN
                    // Down-counter: terminal count 0 is reached on the 32nd BUSY cycle.
                    tmo_d     = 5'd31;
`endif
                end
            end
            S_BUSY: begin
                if (m_done) begin
                    if (owner_q) begin
                        p1_d   = m_r;
                        ack1_d = 1'b1;
                    end else begin
                        p0_d   = m_r;
                        ack0_d = 1'b1;
                    end
                    m_start_d = 1'b0;
                    state_d   = S_ACK;
                end
`ifdef KARATSUBA8_ARB_TIMEOUT_EN
                else if (tmo_q == 5'd0) begin
                    if (owner_q) begin
                        p1_d   = 16'h0000;
                        ack1_d = 1'b1;
                    end else begin
                        p0_d   = 16'h0000;
                        ack0_d = 1'b1;
                    end
                    err_d     = 1'b1;
                    m_start_d = 1'b0;
                    state_d   = S_ACK;
                end else begin
                    tmo_d = tmo_q - 5'd1;
                end
`endif
            end
            S_ACK: begin
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!m_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                m_start_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            prio_q    <= 1'b0;
            owner_q   <= 1'b0;
            m_start_q <= 1'b0;
            m_x_q     <= 8'h00;
            m_y_q     <= 8'h00;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            p0_q      <= 16'h0000;
            p1_q      <= 16'h0000;
            busy_q    <= 1'b0;
`ifdef KARATSUBA8_ARB_TIMEOUT_EN
            tmo_q     <= 5'd0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            owner_q   <= owner_d;
            m_start_q <= m_start_d;
            m_x_q     <= m_x_d;
            m_y_q     <= m_y_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            p0_q      <= p0_d;
            p1_q      <= p1_d;
            busy_q    <= busy_d;
`ifdef KARATSUBA8_ARB_TIMEOUT_EN
            tmo_q     <= tmo_d;
            err_q     <= err_d;
`endif
        end
    end

    assign ack0    = ack0_q;
    assign ack1    = ack1_q;
    assign p0      = p0_q;
    assign p1      = p1_q;
    assign m_start = m_start_q;
    assign m_x     = m_x_q;
    assign m_y     = m_y_q;
    assign busy    = busy_q;
    assign owner   = owner_q;
`ifdef KARATSUBA8_ARB_TIMEOUT_EN
    assign err     = err_q;
`else
    assign err     = 1'b0;
`endif

endmodule
